// File: rtl/dsp_chain_3_operand_feeder_if.sv
// rtl/dsp_chain_3_operand_feeder_if.sv - operand beat stream bundle for the chain feeder
interface dsp_chain_3_operand_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/dsp_chain_3_operand_feeder.sv
// rtl/dsp_chain_3_operand_feeder.sv - beat collector and skewed launch path for a 3-stage fp16 DSP chain
// Option macro: FEEDER_ZERO_BUBBLE_EN (zero the operands of bubble stages instead of holding them)
module dsp_chain_3_operand_feeder #(
  parameter int SKEW = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  dsp_chain_3_operand_feeder_if.slave        s_in,
  input  logic                               hold,
  output logic [15:0]                        top_a1,
  output logic [15:0]                        top_b1,
  output logic [15:0]                        bot_a1,
  output logic [15:0]                        bot_b1,
  output logic [15:0]                        top_a2,
  output logic [15:0]                        top_b2,
  output logic [15:0]                        bot_a2,
  output logic [15:0]                        bot_b2,
  output logic [15:0]                        top_a3,
  output logic [15:0]                        top_b3,
  output logic [15:0]                        bot_a3,
  output logic [15:0]                        bot_b3,
  output logic [2:0]                         stage_valid,
  output logic                               vec_done
);
  localparam int D2 = SKEW;
  localparam int D3 = 2 * SKEW;

  logic [1:0]   gcnt;
  logic         pending;
  logic [63:0]  stg0;
  logic [63:0]  stg1;
  logic [191:0] pend_vec;
  logic         accept;
  logic         complete;
  logic         launch;
  logic [191:0] launch_vec;

  logic         p1_valid;
  logic [63:0]  p1_data;
  logic [D2:0]  p2_valid;
  logic [63:0]  p2_data [0:D2];
  logic [D3:0]  p3_valid;
  logic [63:0]  p3_data [0:D3];

  // A parked vector frees the gather slots, so only the completing beat has to wait.
  assign s_in.in_ready = !reset && !(pending && gcnt == 2'd2);
  assign accept        = s_in.in_valid && s_in.in_ready;
  assign complete      = accept && gcnt == 2'd2;
  assign launch        = !hold && (pending || complete);
  assign launch_vec    = pending ? pend_vec : {stg0, stg1, s_in.in_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt     <= 2'd0;
      pending  <= 1'b0;
      stg0     <= '0;
      stg1     <= '0;
      pend_vec <= '0;
    end else begin
      if (accept) begin
        gcnt <= (gcnt == 2'd2) ? 2'd0 : gcnt + 2'd1;
        if (gcnt == 2'd0) stg0 <= s_in.in_data;
        if (gcnt == 2'd1) stg1 <= s_in.in_data;
      end
      if (complete && hold) begin
        pending  <= 1'b1;
        pend_vec <= {stg0, stg1, s_in.in_data};
      end else if (pending && !hold) begin
        pending <= 1'b0;
      end
    end
  end

  // Index 0 of each line takes the launch; the last index is the stage operand register.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid <= 1'b0;
      p1_data  <= '0;
      p2_valid <= '0;
      p3_valid <= '0;
      for (int i = 0; i <= D2; i++) p2_data[i] <= '0;
      for (int i = 0; i <= D3; i++) p3_data[i] <= '0;
    end else if (!hold) begin
      p1_valid    <= launch;
      p2_valid[0] <= launch;
      p3_valid[0] <= launch;
      for (int i = 1; i <= D2; i++) p2_valid[i] <= p2_valid[i-1];
      for (int i = 1; i <= D3; i++) p3_valid[i] <= p3_valid[i-1];
`ifdef FEEDER_ZERO_BUBBLE_EN
      p1_data    <= launch ? launch_vec[191:128] : 64'h0;
      p2_data[0] <= launch ? launch_vec[127:64]  : 64'h0;
      p3_data[0] <= launch ? launch_vec[63:0]    : 64'h0;
      for (int i = 1; i <= D2; i++) p2_data[i] <= p2_data[i-1];
      for (int i = 1; i <= D3; i++) p3_data[i] <= p3_data[i-1];
`else
      if (launch) begin
        p1_data    <= launch_vec[191:128];
        p2_data[0] <= launch_vec[127:64];
        p3_data[0] <= launch_vec[63:0];
      end
      for (int i = 1; i <= D2; i++) if (p2_valid[i-1]) p2_data[i] <= p2_data[i-1];
      for (int i = 1; i <= D3; i++) if (p3_valid[i-1]) p3_data[i] <= p3_data[i-1];
`endif
    end
  end

  assign {top_a1, top_b1, bot_a1, bot_b1} = p1_data;
  assign {top_a2, top_b2, bot_a2, bot_b2} = p2_data[D2];
  assign {top_a3, top_b3, bot_a3, bot_b3} = p3_data[D3];
  assign stage_valid = {p3_valid[D3], p2_valid[D2], p1_valid};
  assign vec_done    = p3_valid[D3] && !hold;
endmodule
